pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 84 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline types and defaults for the hazard controller.
//   REG_W           register-index width
//   MEM_TIMEOUT_DEF default number of MEM_WAIT cycles before an access is abandoned
//   state_t         memory-wait FSM state
package pipe_hazard_ctrl_pkg;
    localparam int REG_W = 4;
    localparam int MEM_TIMEOUT_DEF = 16;
    typedef enum logic {RUN, MEM_WAIT} state_t;
    typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-status inputs and control outputs of the hazard controller.
//   master: pipeline side, drives stage status, receives freeze/flush/error/statistics
//   slave : hazard controller side
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    reg_idx_t         id_src1;
    reg_idx_t         id_src2;
    logic             id_use_src1;
    logic             id_two_src;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    reg_idx_t         exe_dest;
    logic             mem_wb_en;
    reg_idx_t         mem_dest;
    logic             fwd_en;
    logic             branch_taken;
    logic             mem_req;
    logic             sram_ready;
    logic             freeze_pc;
    logic             freeze_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             freeze_all;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_src1, id_src2, id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en,
               exe_dest, mem_wb_en, mem_dest, fwd_en, branch_taken, mem_req, sram_ready,
        input  freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all, mem_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en,
               exe_dest, mem_wb_en, mem_dest, fwd_en, branch_taken, mem_req, sram_ready,
        output freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all, mem_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational read-after-write hazard check for the ID-stage instruction.
//   i_src1/i_src2, i_use_src1/i_two_src : ID sources and which of them are read
//   i_exe_*, i_mem_*                    : producing instructions in EXE and MEM
//   i_fwd_en                            : forwarding present, only EXE loads still hazard
//   o_hz                                : hazard detected
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  reg_idx_t i_src1,
    input  reg_idx_t i_src2,
    input  logic     i_use_src1,
    input  logic     i_two_src,
    input  logic     i_exe_wb_en,
    input  logic     i_exe_mem_r_en,
    input  reg_idx_t i_exe_dest,
    input  logic     i_mem_wb_en,
    input  reg_idx_t i_mem_dest,
    input  logic     i_fwd_en,
    output logic     o_hz
);
    logic w_exe_src;
    logic w_mem_src;
    logic w_hit1;
    logic w_hit2;

    // With forwarding, EXE results reach ID in time except load data; MEM results always do.
    assign w_exe_src = i_exe_wb_en & (~i_fwd_en | i_exe_mem_r_en);
    assign w_mem_src = i_mem_wb_en & ~i_fwd_en;
    assign w_hit1    = (w_exe_src & (i_exe_dest == i_src1)) | (w_mem_src & (i_mem_dest == i_src1));
    assign w_hit2    = (w_exe_src & (i_exe_dest == i_src2)) | (w_mem_src & (i_mem_dest == i_src2));
    assign o_hz      = (i_use_src1 & w_hit1) | (i_two_src & w_hit2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline freeze/flush controller with memory-wait FSM and event counters.
//   clk : clock, rst : synchronous active-low reset
//   bus : pipe_hazard_ctrl_if.slave carrying stage status in, freeze/flush/mem_err/counters out
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_ctrl_if.slave        bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_hz;
    logic w_mem_stall;
    logic w_branch;
    logic w_hz_stall;
    logic w_timeout;

    hazard_detect u_hazard_detect (
        .i_src1         (bus.id_src1),
        .i_src2         (bus.id_src2),
        .i_use_src1     (bus.id_use_src1),
        .i_two_src      (bus.id_two_src),
        .i_exe_wb_en    (bus.exe_wb_en),
        .i_exe_mem_r_en (bus.exe_mem_r_en),
        .i_exe_dest     (bus.exe_dest),
        .i_mem_wb_en    (bus.mem_wb_en),
        .i_mem_dest     (bus.mem_dest),
        .i_fwd_en       (bus.fwd_en),
        .o_hz           (w_hz)
    );

    // The ready cycle of a wait is not a stall, so branch/hazard logic gets that cycle.
    assign w_mem_stall = rst & ~bus.sram_ready & ((r_state == MEM_WAIT) | bus.mem_req);
    assign w_branch    = rst & ~w_mem_stall & bus.branch_taken;
    assign w_hz_stall  = rst & ~w_mem_stall & ~bus.branch_taken & w_hz;
    assign w_timeout   = (r_state == MEM_WAIT) & ~bus.sram_ready & (r_wait_cnt == WAIT_LAST);

    assign bus.freeze_all  = w_mem_stall;
    assign bus.freeze_pc   = w_mem_stall | w_hz_stall;
    assign bus.freeze_ifid = w_mem_stall | w_hz_stall;
    assign bus.flush_ifid  = w_branch;
    assign bus.flush_idex  = w_branch | w_hz_stall;
    assign bus.mem_err     = r_mem_err;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == RUN) begin
                if (bus.mem_req & ~bus.sram_ready) begin
                    r_state    <= MEM_WAIT;
                    r_wait_cnt <= '0;
                end
            end else if (bus.sram_ready | w_timeout) begin
                r_state <= RUN;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout)
                r_mem_err <= 1'b1;
            if (bus.freeze_pc & ~&r_stall_cnt)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.flush_ifid & ~&r_flush_cnt)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving a default and a small (MEM_TIMEOUT=4, CNT_W=4) controller.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int SM_T = 4;
    localparam int SM_W = 4;

    typedef struct packed {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       two;
        logic       exe_wb;
        logic       exe_rd;
        logic [3:0] exe_dest;
        logic       mem_wb;
        logic [3:0] mem_dest;
        logic       fwd;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        bit wait_st;
        int wcnt;
        bit err;
        int sc;
        int fc;
    } mdl_t;

    typedef struct {
        string      tag;
        logic [5:0] ctl0;
        logic [5:0] ctl1;
        int         sc0;
        int         fc0;
        int         sc1;
        int         fc1;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    stim_t s;
    mdl_t  m0;
    mdl_t  m1;
    exp_t  sb[$];
    int    n_chk = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16))   bus0();
    pipe_hazard_ctrl_if #(.CNT_W(SM_W)) bus1();

    pipe_hazard_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipe_hazard_ctrl #(.MEM_TIMEOUT(SM_T), .CNT_W(SM_W)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always_comb begin
        bus0.id_src1 = s.src1;      bus1.id_src1 = s.src1;
        bus0.id_src2 = s.src2;      bus1.id_src2 = s.src2;
        bus0.id_use_src1 = s.use1;  bus1.id_use_src1 = s.use1;
        bus0.id_two_src = s.two;    bus1.id_two_src = s.two;
        bus0.exe_wb_en = s.exe_wb;  bus1.exe_wb_en = s.exe_wb;
        bus0.exe_mem_r_en = s.exe_rd; bus1.exe_mem_r_en = s.exe_rd;
        bus0.exe_dest = s.exe_dest; bus1.exe_dest = s.exe_dest;
        bus0.mem_wb_en = s.mem_wb;  bus1.mem_wb_en = s.mem_wb;
        bus0.mem_dest = s.mem_dest; bus1.mem_dest = s.mem_dest;
        bus0.fwd_en = s.fwd;        bus1.fwd_en = s.fwd;
        bus0.branch_taken = s.br;   bus1.branch_taken = s.br;
        bus0.mem_req = s.req;       bus1.mem_req = s.req;
        bus0.sram_ready = s.rdy;    bus1.sram_ready = s.rdy;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all, mem_err}
    function automatic logic [5:0] mdl_ctl(mdl_t m, stim_t x, logic r);
        bit hit1, hit2, hz, ms;
        if (x.fwd) begin
            hit1 = x.exe_wb && x.exe_rd && x.exe_dest == x.src1;
            hit2 = x.exe_wb && x.exe_rd && x.exe_dest == x.src2;
        end else begin
            hit1 = (x.exe_wb && x.exe_dest == x.src1) || (x.mem_wb && x.mem_dest == x.src1);
            hit2 = (x.exe_wb && x.exe_dest == x.src2) || (x.mem_wb && x.mem_dest == x.src2);
        end
        hz = (x.use1 && hit1) || (x.two && hit2);
        ms = m.wait_st ? !x.rdy : (x.req && !x.rdy);
        if (!r)  return {5'b00000, m.err};
        if (ms)  return {5'b11001, m.err};
        if (x.br) return {5'b00110, m.err};
        if (hz)  return {5'b11010, m.err};
        return {5'b00000, m.err};
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, stim_t x, logic r, int t, int mx);
        logic [5:0] c;
        mdl_t n;
        c = mdl_ctl(m, x, r);
        n = m;
        if (!r) begin
            n = '{default: 0};
            return n;
        end
        if (c[5] && n.sc < mx) n.sc++;
        if (c[3] && n.fc < mx) n.fc++;
        if (!m.wait_st) begin
            if (x.req && !x.rdy) begin
                n.wait_st = 1;
                n.wcnt = 0;
            end
        end else if (x.rdy) begin
            n.wait_st = 0;
        end else if (m.wcnt == t - 1) begin
            n.wait_st = 0;
            n.err = 1;
        end else begin
            n.wcnt++;
        end
        return n;
    endfunction

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "/ctl0"}, 32'({bus0.freeze_pc, bus0.freeze_ifid, bus0.flush_ifid,
              bus0.flush_idex, bus0.freeze_all, bus0.mem_err}), 32'(e.ctl0));
        check({e.tag, "/ctl1"}, 32'({bus1.freeze_pc, bus1.freeze_ifid, bus1.flush_ifid,
              bus1.flush_idex, bus1.freeze_all, bus1.mem_err}), 32'(e.ctl1));
        check({e.tag, "/stall_cnt0"}, 32'(bus0.stall_cnt), 32'(e.sc0));
        check({e.tag, "/flush_cnt0"}, 32'(bus0.flush_cnt), 32'(e.fc0));
        check({e.tag, "/stall_cnt1"}, 32'(bus1.stall_cnt), 32'(e.sc1));
        check({e.tag, "/flush_cnt1"}, 32'(bus1.flush_cnt), 32'(e.fc1));
    endtask

    task automatic step(string tag, stim_t x, logic r, int n = 1);
        repeat (n) begin
            @(negedge clk);
            s = x;
            rst = r;
            sb.push_back('{tag, mdl_ctl(m0, x, r), mdl_ctl(m1, x, r), m0.sc, m0.fc, m1.sc, m1.fc});
            #2;
            compare_out();
            m0 = mdl_next(m0, x, r, MEM_TIMEOUT_DEF, 65535);
            m1 = mdl_next(m1, x, r, SM_T, (1 << SM_W) - 1);
        end
    endtask

    initial begin
        stim_t h;
        logic [31:0] rnd;
        logic r;
        s = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        m0 = '{default: 0};
        m1 = '{default: 0};

        h = '0; h.req = 1; h.br = 1; h.exe_wb = 1; h.exe_dest = 3; h.src1 = 3; h.use1 = 1;
        step("rst_hold", h, 0, 2);
        h = '0;
        step("idle", h, 1);
        h.exe_wb = 1; h.exe_dest = 3; h.src1 = 3; h.use1 = 1;
        step("hz_exe", h, 1);
        h.fwd = 1;
        step("fwd_noload", h, 1);
        h.exe_rd = 1;
        step("fwd_load", h, 1);
        h.fwd = 0; h.use1 = 0;
        step("src1_unused", h, 1);
        h = '0; h.mem_wb = 1; h.mem_dest = 5; h.src2 = 5; h.two = 1;
        step("hz_mem", h, 1);
        h.fwd = 1;
        step("fwd_mem_ign", h, 1);
        h = '0; h.exe_wb = 1; h.exe_dest = 3; h.src1 = 3; h.use1 = 1; h.br = 1;
        step("branch_hz", h, 1);
        h = '0; h.req = 1;
        step("mem_wait3", h, 1, 3);
        h.rdy = 1; h.br = 1;
        step("mem_ready", h, 1);
        h = '0;
        step("idle", h, 1);
        h.req = 1;
        step("timeout_small", h, 1, 7);
        h.rdy = 1;
        step("release", h, 1);
        h = '0;
        step("err_sticky", h, 1, 3);
        h.req = 1;
        step("timeout_full", h, 1, 18);
        h = '0;
        step("wait_noreq", h, 1);
        h.req = 1;
        step("wait_then_rst", h, 1, 3);
        step("rst_in_wait", h, 0);
        h = '0;
        step("after_rst", h, 1, 2);
        h.exe_wb = 1; h.exe_dest = 7; h.src2 = 7; h.two = 1;
        step("stall_sat", h, 1, 20);
        h = '0; h.br = 1;
        step("flush_sat", h, 1, 20);

        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            h = rnd[24:0];
            h.src1[3:2] = 2'b0;
            h.src2[3:2] = 2'b0;
            h.exe_dest[3:2] = 2'b0;
            h.mem_dest[3:2] = 2'b0;
            h.rdy = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 40) != 0);
            step("random", h, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
